// File: rtl/pll_lock_reset_sequencer_pkg.sv
// Shared types and sizing helpers for the PLL lock reset sequencer.
package pll_lock_seq_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABILIZE = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } seq_state_e;

    // Bits needed to hold every value from 0 up to and including limit.
    function automatic int cnt_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/pll_lock_reset_sequencer_if.sv
// Lock input and staged-reset outputs of the sequencer, grouped as one bundle.
interface pll_lock_reset_sequencer_if #(
    parameter int STAGES         = 3,
    parameter int LOSS_CNT_WIDTH = 8
);
    logic                      locked_async;
    logic [STAGES-1:0]         rst_n_out;
    logic                      ready;
    logic                      lock_lost;
    logic [LOSS_CNT_WIDTH-1:0] loss_count;

    modport master (input locked_async, output rst_n_out, ready, lock_lost, loss_count);
    modport slave  (output locked_async, input rst_n_out, ready, lock_lost, loss_count);
endinterface

// File: rtl/pll_lock_reset_sequencer_sync_2ff.sv
// Generic single-bit two-flop synchronizer, cleared to 0 by a synchronous active-low reset.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic [1:0] sync_q;
    logic [1:0] sync_d;

    always_comb sync_d = {sync_q[0], d};

    always_ff @(posedge clk) begin
        if (!reset) sync_q <= '0;
        else        sync_q <= sync_d;
    end

    assign q = sync_q[1];
endmodule

// File: rtl/pll_lock_reset_sequencer.sv
// Qualifies the PLL lock flag and releases staged active-low resets in index order;
// any lock loss after qualification re-asserts every reset and is counted.
module pll_lock_reset_sequencer
    import pll_lock_seq_pkg::*;
#(
    parameter int STABLE_CYCLES  = 1024,
    parameter int STAGES         = 3,
    parameter int STAGE_GAP      = 16,
    parameter int LOSS_CNT_WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    pll_lock_reset_sequencer_if.master     bus
);
    localparam int CNT_W = cnt_width(STABLE_CYCLES);
    localparam int GAP_W = cnt_width(STAGE_GAP);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST    = GAP_W'(STAGE_GAP - 1);

    logic lk_s;

    sync_2ff u_lock_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bus.locked_async),
        .q     (lk_s)
    );

    seq_state_e                state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [GAP_W-1:0]          gap_q, gap_d;
    logic [STAGES-1:0]         rst_n_q, rst_n_d;
    logic                      ready_q, ready_d;
    logic                      lost_q, lost_d;
    logic [LOSS_CNT_WIDTH-1:0] loss_cnt_q, loss_cnt_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        gap_d      = gap_q;
        rst_n_d    = rst_n_q;
        ready_d    = ready_q;
        lost_d     = 1'b0;
        loss_cnt_d = loss_cnt_q;
        case (state_q)
            WAIT_LOCK: begin
                cnt_d = '0;
                if (lk_s) begin
                    state_d = STABILIZE;
                    cnt_d   = CNT_W'(1);
                end
            end
            STABILIZE: begin
                // A drop here is startup chatter, not a loss: the lock was never qualified.
                if (!lk_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    rst_n_d = STAGES'(1);
                    gap_d   = '0;
                    state_d = RELEASE;
                    if (rst_n_d[STAGES-1]) begin
                        ready_d = 1'b1;
                        state_d = RUN;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RELEASE, RUN: begin
                // Loss takes priority over any stage release scheduled on this edge.
                if (!lk_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                    gap_d   = '0;
                    rst_n_d = '0;
                    ready_d = 1'b0;
                    lost_d  = 1'b1;
                    if (loss_cnt_q != '1) loss_cnt_d = loss_cnt_q + 1'b1;
                end else if (state_q == RELEASE) begin
                    if (gap_q == GAP_LAST) begin
                        gap_d   = '0;
                        rst_n_d = (rst_n_q << 1) | STAGES'(1);
                        if (rst_n_d[STAGES-1]) begin
                            ready_d = 1'b1;
                            state_d = RUN;
                        end
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end
            end
            default: state_d = WAIT_LOCK;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= WAIT_LOCK;
            cnt_q      <= '0;
            gap_q      <= '0;
            rst_n_q    <= '0;
            ready_q    <= 1'b0;
            lost_q     <= 1'b0;
            loss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            gap_q      <= gap_d;
            rst_n_q    <= rst_n_d;
            ready_q    <= ready_d;
            lost_q     <= lost_d;
            loss_cnt_q <= loss_cnt_d;
        end
    end

    assign bus.rst_n_out  = rst_n_q;
    assign bus.ready      = ready_q;
    assign bus.lock_lost  = lost_q;
    assign bus.loss_count = loss_cnt_q;
endmodule

// File: tb/tb_pll_lock_reset_sequencer.sv
// Scoreboard bench: a run-length model of lock qualification predicts outputs per edge.
module tb_pll_lock_reset_sequencer;
    localparam int SC  = 8;
    localparam int ST  = 3;
    localparam int GAP = 4;
    localparam int LW  = 8;

    typedef struct packed {
        logic [ST-1:0] rst;
        logic          rdy;
        logic          lost;
        logic [LW-1:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pll_lock_reset_sequencer_if #(.STAGES(ST), .LOSS_CNT_WIDTH(LW)) bus ();

    pll_lock_reset_sequencer #(
        .STABLE_CYCLES(SC), .STAGES(ST), .STAGE_GAP(GAP), .LOSS_CNT_WIDTH(LW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int   checks = 0;
    int   errors = 0;
    int   printed = 0;
    exp_t exp_q[$];
    bit   started = 0;
    bit   seen_stage1 = 0;
    int   pulses = 0;

    // Reference model: lock samples pass through a 2-deep delay, a run of SC
    // consecutive high samples qualifies the lock, and stage k is out of reset
    // once k*GAP edges have elapsed since qualification.
    bit [1:0] m_sh;
    bit       m_qual;
    int       m_run, m_t, m_cnt;
    bit       m_lost;

    task automatic report(input string name, input exp_t act, input exp_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (printed < 30) begin
                printed++;
                $display("FAIL %s at %0t: got rst=%b rdy=%b lost=%b cnt=%0d, expected rst=%b rdy=%b lost=%b cnt=%0d",
                         name, $time, act.rst, act.rdy, act.lost, act.cnt,
                         exp.rst, exp.rdy, exp.lost, exp.cnt);
            end
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        int   n;
        n = 0;
        if (m_qual) begin
            n = m_t / GAP + 1;
            if (n > ST) n = ST;
        end
        e.rst  = ST'((1 << n) - 1);
        e.rdy  = m_qual && (m_t >= (ST - 1) * GAP);
        e.lost = m_lost;
        e.cnt  = LW'(m_cnt);
        return e;
    endfunction

    task automatic model_edge(input logic r, input logic l);
        bit lk;
        if (!r) begin
            m_sh = '0; m_qual = 0; m_run = 0; m_t = 0; m_cnt = 0; m_lost = 0;
        end else begin
            lk     = m_sh[1];
            m_lost = 0;
            if (!m_qual) begin
                if (lk) begin
                    m_run++;
                    if (m_run == SC) begin m_qual = 1; m_t = 0; end
                end else begin
                    m_run = 0;
                end
            end else if (!lk) begin
                m_qual = 0; m_run = 0; m_lost = 1;
                if (m_cnt < (1 << LW) - 1) m_cnt++;
            end else if (m_t < 1000) begin
                m_t++;
            end
            m_sh = {m_sh[0], l};
        end
    endtask

    task automatic step(input logic r, input logic l);
        reset = r;
        bus.locked_async = l;
        started = 1;
        @(posedge clk);
        model_edge(r, l);
        exp_q.push_back(model_out());
        #1;
    endtask

    task automatic steps(input int n, input logic r, input logic l);
        for (int i = 0; i < n; i++) step(r, l);
    endtask

    always @(negedge clk) begin
        exp_t act;
        if (started) begin
            act = {bus.rst_n_out, bus.ready, bus.lock_lost, bus.loss_count};
            if (bus.rst_n_out[1]) seen_stage1 = 1;
            if (bus.lock_lost) pulses++;
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL scoreboard_empty at %0t: got output with no expectation, expected queued entry", $time);
            end else begin
                report("outputs", act, exp_q.pop_front());
            end
        end
    end

    initial begin
        int cnt_prev, h, l;
        reset = 1'b0;
        bus.locked_async = 1'b0;

        // Reset held with lock present, then steady lock through the full release.
        steps(3, 0, 1);
        steps(24, 1, 1);

        // Startup chatter: a one-cycle glitch restarts qualification, no loss counted.
        steps(2, 0, 0);
        steps(5, 1, 1);
        steps(1, 1, 0);
        steps(24, 1, 1);

        // Loss while running, then re-lock.
        steps(3, 1, 0);
        steps(24, 1, 1);

        // Loss on the edge where stage 1 would be released.
        steps(3, 1, 0);
        for (int i = 0; i < 100 && !m_qual; i++) step(1, 1);
        check_int("qualify_before_drop", int'(m_qual), 1);
        seen_stage1 = 0;
        cnt_prev = m_cnt;
        steps(GAP - 3, 1, 1);
        steps(3, 1, 0);
        @(negedge clk); #1;
        check_int("stage1_never_released", int'(seen_stage1), 0);
        check_int("loss_count_after_stage1_drop", int'(bus.loss_count), cnt_prev + 1);
        check_int("rst_after_stage1_drop", int'(bus.rst_n_out), 0);
        steps(24, 1, 1);

        // Reset in the middle of the release sequence.
        steps(3, 1, 0);
        for (int i = 0; i < 100 && model_out().rst != 3'b011; i++) step(1, 1);
        check_int("reach_rst_011", int'(model_out().rst), 3);
        step(0, 1);
        @(negedge clk); #1;
        check_int("mid_release_reset_rst", int'(bus.rst_n_out), 0);
        check_int("mid_release_reset_cnt", int'(bus.loss_count), 0);
        steps(26, 1, 1);

        // Randomized lock/unlock activity with occasional reset.
        for (int s = 0; s < 150; s++) begin
            if ($urandom_range(0, 49) == 0) steps($urandom_range(1, 2), 0, 1'($urandom_range(0, 1)));
            h = $urandom_range(1, 25);
            l = $urandom_range(1, 4);
            steps(h, 1, 1);
            steps(l, 1, 0);
        end

        // Saturation of the loss counter over 300 qualified losses.
        steps(2, 0, 0);
        @(negedge clk); #1;
        pulses = 0;
        for (int e = 0; e < 300; e++) begin
            steps(12, 1, 1);
            steps(2, 1, 0);
        end
        steps(3, 1, 1);
        @(negedge clk); #1;
        check_int("loss_count_saturated", int'(bus.loss_count), 255);
        check_int("lock_lost_pulses", pulses, 300);
        check_int("scoreboard_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end
endmodule
